// File: rtl/lcd_timing_pkg.sv
// ---------------------------------------------------------------------------
// lcd_timing_pkg
// Shared constants for the 480x272 RGB LCD timing generator:
//   - default horizontal / vertical timing (pixel clocks / lines)
//   - derived line and frame totals and the counter widths they need
//   - RGB565 pixel type and the 8-entry colour-bar table
// ---------------------------------------------------------------------------
package lcd_timing_pkg;

   // Default panel timing (480x272 panel set).
   localparam int H_ACTIVE_DEF = 480;
   localparam int H_FP_DEF     = 2;
   localparam int H_SYNC_DEF   = 41;
   localparam int H_BP_DEF     = 2;
   localparam int V_ACTIVE_DEF = 272;
   localparam int V_FP_DEF     = 2;
   localparam int V_SYNC_DEF   = 10;
   localparam int V_BP_DEF     = 2;
   localparam int BAR_W_DEF    = 60;

   localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 525
   localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 286

   // Width of a counter holding 0..n-1; never below one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int H_CNT_W_DEF = cnt_width(H_TOTAL_DEF);  // 10
   localparam int V_CNT_W_DEF = cnt_width(V_TOTAL_DEF);  // 9

   // Width of the pix_x / pix_y coordinate outputs.
   localparam int COORD_W = 9;

   localparam int BAR_N     = 8;
   localparam int BAR_IDX_W = 3;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   // Colour bars in index order: white, yellow, cyan, green,
   // magenta, red, blue, black.
   localparam rgb565_t BAR_COLOR [BAR_N] = '{
      16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
      16'hF81F, 16'hF800, 16'h001F, 16'h0000
   };

endpackage

// File: rtl/lcd_axis_cnt.sv
// ---------------------------------------------------------------------------
// lcd_axis_cnt
// One timing axis (horizontal or vertical): a wrapping position counter with
// phase decode. Phase order along the axis: sync, back porch, active, front
// porch.
//
// Ports:
//   clk, rst   pixel clock, asynchronous active-high reset
//   en         run enable; low holds the counter at 0
//   step       advance the counter by one position this cycle
//   cnt        current position, 0..TOTAL-1
//   in_sync    position lies in the sync phase
//   in_active  position lies in the active phase
//   coord      position relative to the start of active, 0 outside active
// ---------------------------------------------------------------------------
module lcd_axis_cnt
   import lcd_timing_pkg::*;
#(
   parameter int ACTIVE    = H_ACTIVE_DEF,
   parameter int FP        = H_FP_DEF,
   parameter int SYNC      = H_SYNC_DEF,
   parameter int BP        = H_BP_DEF,
   parameter int CNT_W     = cnt_width(ACTIVE + FP + SYNC + BP),
   parameter int OUT_W     = COORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             step,
   output logic [CNT_W-1:0] cnt,
   output logic             in_sync,
   output logic             in_active,
   output logic [OUT_W-1:0] coord
);

   localparam int TOTAL = ACTIVE + FP + SYNC + BP;

   localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] ACT_START = CNT_W'(SYNC + BP);
   // One bit wider so the end bound still fits when the front porch is 0.
   localparam logic [CNT_W:0]   SYNC_END  = (CNT_W + 1)'(SYNC);
   localparam logic [CNT_W:0]   ACT_END   = (CNT_W + 1)'(SYNC + BP + ACTIVE);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the block can leave it unassigned and infer a latch.
      cnt_d = cnt_q;
      if (!en) begin
         cnt_d = '0;
      end else if (step) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples its inputs from before the edge, independent of block order.
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt       = cnt_q;
   assign in_sync   = ({1'b0, cnt_q} < SYNC_END);
   assign in_active = (cnt_q >= ACT_START) && ({1'b0, cnt_q} < ACT_END);
   assign coord     = in_active ? OUT_W'(cnt_q - ACT_START) : '0;

endmodule

// File: rtl/lcd_timing_gen.sv
// ---------------------------------------------------------------------------
// lcd_timing_gen
// Timing and colour-bar pattern generator for a parallel RGB565 LCD.
// Two lcd_axis_cnt instances produce the horizontal/vertical position; this
// level adds the colour-bar counter, the colour lookup and one stage of
// output registers so syncs, de, rgb and coordinates share 1 clk latency
// and are glitch-free.
//
// Ports:
//   clk           pixel clock
//   rst           asynchronous active-high reset
//   en            run enable; low aborts the frame and idles the outputs
//   lcd_hsync_n   horizontal sync, active low
//   lcd_vsync_n   vertical sync, active low
//   lcd_de        data enable, high on active pixels
//   lcd_r/g/b     RGB565 pixel data, 0 while lcd_de is low
//   pix_x/pix_y   active-area coordinate, 0 while lcd_de is low
//   frame_start   one-cycle pulse on the first cycle of each frame
// ---------------------------------------------------------------------------
module lcd_timing_gen
   import lcd_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter int BAR_W    = BAR_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic               lcd_hsync_n,
   output logic               lcd_vsync_n,
   output logic               lcd_de,
   output logic [4:0]         lcd_r,
   output logic [5:0]         lcd_g,
   output logic [4:0]         lcd_b,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic               frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_W     = cnt_width(H_TOTAL);
   localparam int V_W     = cnt_width(V_TOTAL);
   localparam int BAR_PW  = cnt_width(BAR_W);

   localparam logic [H_W-1:0]       H_LAST   = H_W'(H_TOTAL - 1);
   localparam logic [BAR_PW-1:0]    BAR_LAST = BAR_PW'(BAR_W - 1);
   localparam logic [BAR_IDX_W-1:0] IDX_MAX  = BAR_IDX_W'(BAR_N - 1);

   // ---------------------------------------------------------------- axes
   logic [H_W-1:0]     h_cnt;
   logic [V_W-1:0]     v_cnt;
   logic               h_sync, h_active, v_sync, v_active;
   logic [COORD_W-1:0] h_coord, v_coord;
   logic               h_last;

   lcd_axis_cnt #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .CNT_W  (H_W),
      .OUT_W  (COORD_W)
   ) u_h_axis (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .step      (1'b1),
      .cnt       (h_cnt),
      .in_sync   (h_sync),
      .in_active (h_active),
      .coord     (h_coord)
   );

   // The vertical axis advances on the last pixel of every line.
   assign h_last = (h_cnt == H_LAST);

   lcd_axis_cnt #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .CNT_W  (V_W),
      .OUT_W  (COORD_W)
   ) u_v_axis (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .step      (h_last),
      .cnt       (v_cnt),
      .in_sync   (v_sync),
      .in_active (v_active),
      .coord     (v_coord)
   );

   // --------------------------------------------------------- bar counter
   // bar_idx_q/bar_pix_q describe the pixel at the current h_cnt. They sit
   // at 0 on every non-active pixel, so each active line starts at bar 0;
   // the index then steps every BAR_W pixels and sticks at the last bar.
   logic [BAR_IDX_W-1:0] bar_idx_q, bar_idx_d;
   logic [BAR_PW-1:0]    bar_pix_q, bar_pix_d;

   always_comb begin
      bar_idx_d = bar_idx_q;
      bar_pix_d = bar_pix_q;
      if (!en || !h_active) begin
         bar_idx_d = '0;
         bar_pix_d = '0;
      end else if (bar_pix_q == BAR_LAST) begin
         bar_pix_d = '0;
         if (bar_idx_q != IDX_MAX) begin
            bar_idx_d = bar_idx_q + 1'b1;
         end
      end else begin
         bar_pix_d = bar_pix_q + 1'b1;
      end
   end

   // ------------------------------------------------------ output stage
   logic               hsync_n_q, hsync_n_d;
   logic               vsync_n_q, vsync_n_d;
   logic               de_q, de_d;
   rgb565_t            rgb_q, rgb_d;
   logic [COORD_W-1:0] pix_x_q, pix_x_d;
   logic [COORD_W-1:0] pix_y_q, pix_y_d;
   logic               frame_start_q, frame_start_d;

   // Everything is gated by en: with en low the counters sit at 0, which
   // would otherwise decode as sync and frame start.
   always_comb begin
      de_d          = en && h_active && v_active;
      hsync_n_d     = !(en && h_sync);
      vsync_n_d     = !(en && v_sync);
      rgb_d         = de_d ? BAR_COLOR[bar_idx_q] : '0;
      pix_x_d       = de_d ? h_coord : '0;
      pix_y_d       = de_d ? v_coord : '0;
      frame_start_d = en && (h_cnt == '0) && (v_cnt == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bar_idx_q     <= '0;
         bar_pix_q     <= '0;
         hsync_n_q     <= 1'b1;
         vsync_n_q     <= 1'b1;
         de_q          <= 1'b0;
         rgb_q         <= '0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         frame_start_q <= 1'b0;
      end else begin
         bar_idx_q     <= bar_idx_d;
         bar_pix_q     <= bar_pix_d;
         hsync_n_q     <= hsync_n_d;
         vsync_n_q     <= vsync_n_d;
         de_q          <= de_d;
         rgb_q         <= rgb_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign lcd_hsync_n = hsync_n_q;
   assign lcd_vsync_n = vsync_n_q;
   assign lcd_de      = de_q;
   assign lcd_r       = rgb_q.r;
   assign lcd_g       = rgb_q.g;
   assign lcd_b       = rgb_q.b;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_lcd_timing_gen
// Directed bench for lcd_timing_gen. Instance dut_a uses the 480x272 default
// timing, dut_s the 8x4 reduced timing with 1-pixel bars, dut_t a 10-pixel
// line with 1-pixel bars to exercise bar-index saturation. Expected values
// are hand-computed from the timing parameters; sample n below is the n-th
// enabled cycle, whose outputs appear after the following clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_timing_gen;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en_a = 1'b0;
   logic en_s = 1'b0;
   logic en_t = 1'b0;

   always #5 clk = ~clk;

   logic       hs_a, vs_a, de_a, fs_a;
   logic [4:0] r_a, b_a;
   logic [5:0] g_a;
   logic [8:0] x_a, y_a;

   logic       hs_s, vs_s, de_s, fs_s;
   logic [4:0] r_s, b_s;
   logic [5:0] g_s;
   logic [8:0] x_s, y_s;

   logic       hs_t, vs_t, de_t, fs_t;
   logic [4:0] r_t, b_t;
   logic [5:0] g_t;
   logic [8:0] x_t, y_t;

   lcd_timing_gen dut_a (
      .clk(clk), .rst(rst), .en(en_a),
      .lcd_hsync_n(hs_a), .lcd_vsync_n(vs_a), .lcd_de(de_a),
      .lcd_r(r_a), .lcd_g(g_a), .lcd_b(b_a),
      .pix_x(x_a), .pix_y(y_a), .frame_start(fs_a)
   );

   lcd_timing_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .BAR_W(1)
   ) dut_s (
      .clk(clk), .rst(rst), .en(en_s),
      .lcd_hsync_n(hs_s), .lcd_vsync_n(vs_s), .lcd_de(de_s),
      .lcd_r(r_s), .lcd_g(g_s), .lcd_b(b_s),
      .pix_x(x_s), .pix_y(y_s), .frame_start(fs_s)
   );

   lcd_timing_gen #(
      .H_ACTIVE(10), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .BAR_W(1)
   ) dut_t (
      .clk(clk), .rst(rst), .en(en_t),
      .lcd_hsync_n(hs_t), .lcd_vsync_n(vs_t), .lcd_de(de_t),
      .lcd_r(r_t), .lcd_g(g_t), .lcd_b(b_t),
      .pix_x(x_t), .pix_y(y_t), .frame_start(fs_t)
   );

   // Expected bar colours: white, yellow, cyan, green, magenta, red, blue, black.
   localparam logic [15:0] COLORS [8] = '{
      16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
      16'hF81F, 16'hF800, 16'h001F, 16'h0000
   };

   // Sampled pixel positions on the first active line and their bar index.
   localparam int NV = 12;
   localparam int VX [NV] = '{0, 59, 60, 119, 120, 180, 240, 300, 360, 419, 420, 479};
   localparam int VI [NV] = '{0,  0,  1,   1,   2,   3,   4,   5,   6,   6,   7,   7};

   localparam int FIRST_DE = 12 * 525 + 43;  // 6343
   localparam int WIN      = 13 * 525;       // lines 0..12

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int hs_line0, hs_total, hs_fall2, vs_low, fs_cnt, fs_first;
      int de_cnt, first_de, fx, fy, idle_bad;
      logic hs_prev;
      int de_s_cnt, fs_s_cnt, hs_s_low, vs_s_low, bad_s;
      logic [7:0] line_mask [8];

      // Asynchronous reset before any clock edge.
      #2 rst = 1'b1;
      #1;
      check("rst_sync_de_fs", {29'd0, hs_a, vs_a, de_a, fs_a}, 32'b1100);
      check("rst_rgb", {16'd0, r_a, g_a, b_a}, 32'h0);
      check("rst_xy", {14'd0, x_a, y_a}, 32'h0);

      tick();
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("idle_en_low", {29'd0, hs_a, vs_a, de_a, fs_a}, 32'b1100);

      // Default timing: 13 full lines from the first enabled cycle.
      en_a = 1'b1;
      hs_line0 = 0; hs_total = 0; hs_fall2 = -1; vs_low = 0;
      fs_cnt = 0; fs_first = -1; de_cnt = 0; first_de = -1; fx = -1; fy = -1;
      hs_prev = 1'b1;
      for (int n = 0; n < WIN; n++) begin
         tick();
         if (!hs_a) begin
            hs_total++;
            if (n < 525) hs_line0++;
         end
         if (hs_prev && !hs_a && n > 0 && hs_fall2 < 0) hs_fall2 = n;
         hs_prev = hs_a;
         if (!vs_a) vs_low++;
         if (fs_a) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = n;
         end
         if (de_a) begin
            de_cnt++;
            if (first_de < 0) begin
               first_de = n;
               fx = int'(x_a);
               fy = int'(y_a);
            end
         end
         for (int i = 0; i < NV; i++) begin
            if (n == FIRST_DE + VX[i])
               check($sformatf("bar_rgb_x%0d", VX[i]), {16'd0, r_a, g_a, b_a}, {16'd0, COLORS[VI[i]]});
         end
         if (n == FIRST_DE + 479) check("pix_x_479", {23'd0, x_a}, 32'd479);
         if (n == FIRST_DE - 1) begin
            check("rgb_back_porch", {16'd0, r_a, g_a, b_a}, 32'h0);
            check("xy_back_porch", {14'd0, x_a, y_a}, 32'h0);
         end
         if (n == FIRST_DE + 480) begin
            check("rgb_front_porch", {16'd0, r_a, g_a, b_a}, 32'h0);
            check("de_front_porch", {31'd0, de_a}, 32'd0);
         end
      end
      check("hsync_low_line0", hs_line0, 41);
      check("hsync_low_13_lines", hs_total, 13 * 41);
      check("hsync_period", hs_fall2, 525);
      check("vsync_low_clks", vs_low, 10 * 525);
      check("frame_start_cnt", fs_cnt, 1);
      check("frame_start_pos", fs_first, 0);
      check("first_de_pos", first_de, FIRST_DE);
      check("first_de_x", fx, 0);
      check("first_de_y", fy, 0);
      check("de_line12_cnt", de_cnt, 480);

      // Into line 13 (second active line), pixel 200.
      repeat (244) tick();
      check("mid_de", {31'd0, de_a}, 32'd1);
      check("mid_x", {23'd0, x_a}, 32'd200);
      check("mid_y", {23'd0, y_a}, 32'd1);
      check("mid_rgb", {16'd0, r_a, g_a, b_a}, {16'd0, COLORS[3]});

      // Drop en mid-line for 50 clocks.
      en_a = 1'b0;
      idle_bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if ({hs_a, vs_a, de_a, fs_a} !== 4'b1100 || {r_a, g_a, b_a} !== 16'h0 ||
             x_a !== 9'd0 || y_a !== 9'd0)
            idle_bad++;
      end
      check("en_gap_idle_bad", idle_bad, 0);

      en_a = 1'b1;
      tick();
      check("reenable_fs_hs_vs_de", {28'd0, fs_a, hs_a, vs_a, de_a}, 32'b1000);
      tick();
      check("reenable_fs_one_cycle", {31'd0, fs_a}, 32'd0);

      // Run to pixel 100 of the first active line, then reset mid-cycle.
      repeat (FIRST_DE + 100 - 1) tick();
      check("pre_rst_de", {31'd0, de_a}, 32'd1);
      check("pre_rst_x", {23'd0, x_a}, 32'd100);
      #2 rst = 1'b1;
      #1;
      check("async_rst_sync_de_fs", {29'd0, hs_a, vs_a, de_a, fs_a}, 32'b1100);
      check("async_rst_rgb", {16'd0, r_a, g_a, b_a}, 32'h0);
      check("async_rst_xy", {14'd0, x_a, y_a}, 32'h0);
      #1 rst = 1'b0;
      tick();
      check("post_rst_frame_start", {29'd0, fs_a, hs_a, vs_a}, 32'b100);

      // Reduced timings: 11x7 (dut_s) and 13x7 (dut_t).
      en_s = 1'b1;
      en_t = 1'b1;
      de_s_cnt = 0; fs_s_cnt = 0; hs_s_low = 0; vs_s_low = 0; bad_s = 0;
      for (int i = 0; i < 8; i++) line_mask[i] = 8'h00;
      for (int n = 0; n < 182; n++) begin
         tick();
         if (n < 154) begin
            int h, v, li;
            logic act;
            h = n % 11;
            v = (n / 11) % 7;
            act = (h >= 2) && (h < 10) && (v >= 2) && (v < 6);
            if (de_s) de_s_cnt++;
            if (fs_s) fs_s_cnt++;
            if (!hs_s) hs_s_low++;
            if (!vs_s) vs_s_low++;
            if (de_s !== act || hs_s !== (h != 0) || vs_s !== (v != 0) ||
                {r_s, g_s, b_s} !== (act ? COLORS[h - 2] : 16'h0) ||
                x_s !== (act ? 9'(h - 2) : 9'd0) || y_s !== (act ? 9'(v - 2) : 9'd0))
               bad_s++;
            if (act) begin
               li = (n / 77) * 4 + (v - 2);
               for (int c = 0; c < 8; c++)
                  if ({r_s, g_s, b_s} === COLORS[c]) line_mask[li][c] = 1'b1;
            end
         end
         // dut_t: first active line starts at n = 2*13 + 2 = 28.
         if (n == 28)      check("sat_x0_white", {16'd0, r_t, g_t, b_t}, {16'd0, COLORS[0]});
         if (n == 28 + 6)  check("sat_x6_blue",  {16'd0, r_t, g_t, b_t}, {16'd0, COLORS[6]});
         if (n == 28 + 8) begin
            check("sat_x8_de",    {31'd0, de_t}, 32'd1);
            check("sat_x8_black", {16'd0, r_t, g_t, b_t}, 32'h0);
         end
         if (n == 28 + 9)  check("sat_x9_black", {16'd0, r_t, g_t, b_t}, 32'h0);
         if (n == 28 + 13) check("sat_next_line_white", {16'd0, r_t, g_t, b_t}, {16'd0, COLORS[0]});
      end
      check("small_de_cnt_2frames", de_s_cnt, 64);
      check("small_fs_cnt_2frames", fs_s_cnt, 2);
      check("small_hsync_low", hs_s_low, 14);
      check("small_vsync_low", vs_s_low, 22);
      check("small_bad_samples", bad_s, 0);
      for (int i = 0; i < 8; i++)
         check($sformatf("small_line%0d_colours", i), {24'd0, line_mask[i]}, 32'h0000_00FF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
